// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master.
//   state_t    : transfer sequencer states
//   spi_mode_t : per-transfer clock polarity / phase
//   cnt_w()    : width of a counter that runs 0..n-1
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Bits needed to hold the terminal count n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for spi_mstr_cfg.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run the divider (high during SHIFT)
//   cpol       : idle level loaded into SCLK while cleared
//   clear      : hold counters at zero and park SCLK at cpol
//   sclk       : registered serial clock
//   lead_stb   : SCLK is about to make a leading edge (this cycle)
//   trail_stb  : SCLK is about to make a trailing edge (this cycle)
//   last_edge  : the final trailing edge of the word is being made
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int HALF_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cpol,
    input  logic clear,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam int DIV_W  = cnt_w(HALF_DIV);
    localparam int EDGE_W = cnt_w(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0]  div_reg;
    logic [EDGE_W-1:0] edge_reg;
    logic              sclk_reg;
    logic              wrap;

    // A toggle happens at the end of every cycle where the divider wraps.
    assign wrap = en && !clear && (div_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            edge_reg <= '0;
            sclk_reg <= 1'b0;
        end else if (clear) begin
            div_reg  <= '0;
            edge_reg <= '0;
            sclk_reg <= cpol;
        end else if (en) begin
            if (wrap) begin
                div_reg  <= '0;
                sclk_reg <= ~sclk_reg;
                edge_reg <= (edge_reg == EDGE_LAST) ? '0 : edge_reg + 1'b1;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

    // Even edge indices leave the idle level (leading), odd ones return to it.
    assign lead_stb  = wrap && !edge_reg[0];
    assign trail_stb = wrap && edge_reg[0];
    assign last_edge = wrap && (edge_reg == EDGE_LAST);
    assign sclk      = sclk_reg;

endmodule

// File: rtl/spi_mstr_cfg.sv
// Parametrised full-duplex SPI master with per-transfer CPOL/CPHA.
//   clk, rst_n : clock, asynchronous active-low reset
//   wrt        : start request (taken only when idle)
//   cmd        : word to transmit, MSB first
//   ss_sel     : slave index (out-of-range index runs with no select)
//   cpol, cpha : SPI mode for this transfer
//   MISO       : serial input, asynchronous to clk
//   SCLK, MOSI : registered serial clock / data out
//   SS_n       : active-low slave selects
//   busy       : sequencer not idle
//   done       : one-cycle pulse, data valid from here on
//   data       : last received word
// SETUP and HOLD each last GUARD_CLKS cycles; GUARD_CLKS must be >= 3 so the
// delayed capture of the final trailing edge lands before DONE.
module spi_mstr_cfg
    import spi_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int HALF_DIV   = 16,
    parameter  int NUM_SS     = 2,
    parameter  int GUARD_CLKS = 8,
    localparam int SEL_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data
);

    localparam int GUARD_W = cnt_w(GUARD_CLKS);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CLKS - 1);

    state_t             state_reg, state_next;
    logic               accept;
    logic [GUARD_W-1:0] guard_reg;
    logic               guard_end;
    spi_mode_t          mode_reg, mode_in;
    logic [DATA_W-1:0]  tx_reg, rx_reg, data_reg;
    logic [NUM_SS-1:0]  ss_n_reg, ss_dec;
    logic               mosi_reg, done_reg;
    logic               miso_s1_reg, miso_s2_reg;
    logic               cap_d1_reg, cap_d2_reg;
    logic               lead_seen_reg;
    logic               sclk_cpol, lead_stb, trail_stb, last_edge;
    logic               cap_stb, tx_shift_stb;

    assign mode_in = {cpol, cpha};

    // One-hot-low select decode; an index with no matching slave leaves all high.
    for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
        assign ss_dec[gi] = (ss_sel != SEL_W'(gi));
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (wrt) begin
                    state_next = SETUP;
                    accept     = 1'b1;
                end
            end
            SETUP:   if (guard_end) state_next = SHIFT;
            SHIFT:   if (last_edge) state_next = HOLD;
            HOLD:    if (guard_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign guard_end = (guard_reg == GUARD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_reg <= '0;
        end else if ((state_reg == SETUP || state_reg == HOLD) && !guard_end) begin
            guard_reg <= guard_reg + 1'b1;
        end else begin
            guard_reg <= '0;
        end
    end

    // ---------------- SCLK ----------------
    // The new polarity goes straight in on accept so SCLK is already at the
    // right idle level in the first SETUP cycle.
    assign sclk_cpol = accept ? cpol : mode_reg.cpol;

    spi_sclk_gen #(
        .DATA_W   (DATA_W),
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_reg == SHIFT),
        .cpol      (sclk_cpol),
        .clear     (state_reg != SHIFT),
        .sclk      (SCLK),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    // cpha=1 skips the first leading edge: the MSB is already on MOSI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lead_seen_reg <= 1'b0;
        end else if (state_reg != SHIFT) begin
            lead_seen_reg <= 1'b0;
        end else if (lead_stb) begin
            lead_seen_reg <= 1'b1;
        end
    end

    assign cap_stb      = mode_reg.cpha ? trail_stb : lead_stb;
    assign tx_shift_stb = mode_reg.cpha ? (lead_stb && lead_seen_reg)
                                        : (trail_stb && !last_edge);

    // ---------------- transmit side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg   <= '0;
            mode_reg <= '0;
            mosi_reg <= 1'b0;
            ss_n_reg <= '1;
        end else if (accept) begin
            tx_reg   <= cmd;
            mode_reg <= mode_in;
            mosi_reg <= cmd[DATA_W-1];
            ss_n_reg <= ss_dec;
        end else if (tx_shift_stb) begin
            tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
            mosi_reg <= tx_reg[DATA_W-2];
        end else if (state_reg == DONE) begin
            mosi_reg <= 1'b0;
            ss_n_reg <= '1;
        end
    end

    // ---------------- receive side ----------------
    // MISO is sampled two cycles after the SCLK toggle through the synchroniser;
    // the strobe is delayed by the same two cycles to line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1_reg <= 1'b0;
            miso_s2_reg <= 1'b0;
            cap_d1_reg  <= 1'b0;
            cap_d2_reg  <= 1'b0;
            rx_reg      <= '0;
            done_reg    <= 1'b0;
            data_reg    <= '0;
        end else begin
            miso_s1_reg <= MISO;
            miso_s2_reg <= miso_s1_reg;
            cap_d1_reg  <= cap_stb;
            cap_d2_reg  <= cap_d1_reg;
            if (cap_d2_reg) begin
                rx_reg <= {rx_reg[DATA_W-2:0], miso_s2_reg};
            end
            done_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                data_reg <= rx_reg;
            end
        end
    end

    assign MOSI = mosi_reg;
    assign SS_n = ss_n_reg;
    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign data = data_reg;

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Self-checking bench for spi_mstr_cfg: default instance driven against a
// behavioural SPI slave, plus a small 8-bit loopback instance.
module tb_spi_mstr_cfg;

    localparam int LAT  = 2 * 8 + 2 * 16 * 16 + 1;  // 529
    localparam int LAT8 = 2 * 8 + 2 * 8 * 4 + 1;    // 81

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic        rst_n, wrt, cpol, cpha, miso;
    logic [15:0] cmd, data;
    logic [0:0]  ss_sel;
    logic        sclk, mosi, busy, done;
    logic [1:0]  ss_n;

    spi_mstr_cfg #(
        .DATA_W(16), .HALF_DIV(16), .NUM_SS(2), .GUARD_CLKS(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .MISO(miso), .SCLK(sclk), .MOSI(mosi),
        .SS_n(ss_n), .busy(busy), .done(done), .data(data)
    );

    // small loopback instance, single select tied to an out-of-range index
    logic       wrt8, sclk8, mosi8, busy8, done8;
    logic [7:0] cmd8, data8;
    logic [0:0] ss_sel8, ss_n8;
    assign ss_sel8 = 1'b1;

    spi_mstr_cfg #(
        .DATA_W(8), .HALF_DIV(4), .NUM_SS(1), .GUARD_CLKS(8)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .wrt(wrt8), .cmd(cmd8), .ss_sel(ss_sel8),
        .cpol(1'b0), .cpha(1'b0), .MISO(mosi8), .SCLK(sclk8), .MOSI(mosi8),
        .SS_n(ss_n8), .busy(busy8), .done(done8), .data(data8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // scoreboard
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] mosi;
        logic [1:0]  ss;
    } exp_t;
    exp_t        sb_q[$];
    logic [15:0] rsp_q[$];

    // slave model: drives MISO / samples MOSI according to the current mode
    logic        slv_cpol = 1'b0, slv_cpha = 1'b0;
    logic [15:0] slv_rx = '0;

    initial begin
        logic        sclk_p, act_p, act_now, lead;
        logic [15:0] slv_tx;
        sclk_p = 1'b0;
        act_p  = 1'b0;
        slv_tx = '0;
        miso   = 1'b0;
        forever begin
            @(negedge clk);
            act_now = (ss_n != 2'b11);
            if (act_now && !act_p) begin
                slv_tx = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'h0;
                slv_rx = '0;
                if (!slv_cpha) begin
                    miso   = slv_tx[15];
                    slv_tx = slv_tx << 1;
                end
            end else if (act_now && (sclk != sclk_p)) begin
                lead = (sclk_p == slv_cpol);
                if (lead ^ slv_cpha) begin
                    slv_rx = {slv_rx[14:0], mosi};
                end else begin
                    miso   = slv_tx[15];
                    slv_tx = slv_tx << 1;
                end
            end
            sclk_p = sclk;
            act_p  = act_now;
        end
    end

    // completion monitor: pops the scoreboard on every done pulse
    initial begin
        logic       busy_p;
        int         acc_cyc;
        logic [1:0] ss_and, ss_or;
        exp_t       e;
        busy_p  = 1'b0;
        acc_cyc = 0;
        ss_and  = '1;
        ss_or   = '0;
        forever begin
            @(negedge clk);
            if (busy && !busy_p) begin
                acc_cyc = cyc;
                ss_and  = '1;
                ss_or   = '0;
            end
            if (busy) begin
                ss_and = ss_and & ss_n;
                ss_or  = ss_or | ss_n;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", cyc - acc_cyc, LAT);
                    check("data", data, e.data);
                    check("mosi_word", slv_rx, e.mosi);
                    check("ss_n_and", ss_and, e.ss);
                    check("ss_n_or", ss_or, e.ss);
                    check("ss_n_at_done", ss_n, 2'b11);
                    check("busy_at_done", busy, 1'b0);
                    n_done++;
                end
                $display("xfer done: data=%h slave_saw=%h cycle=%0d", data, slv_rx, cyc);
            end
            busy_p = busy;
        end
    end

    task automatic start_xfer(input logic [15:0] c, input logic [15:0] rsp,
                              input logic s, input logic p, input logic h);
        @(negedge clk);
        cmd = c; ss_sel = s; cpol = p; cpha = h;
        slv_cpol = p; slv_cpha = h;
        wrt = 1'b1;
        rsp_q.push_back(rsp);
        sb_q.push_back('{data: rsp, mosi: c, ss: (s ? 2'b01 : 2'b10)});
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n0, t0, n;
        logic ss8_and;
        rst_n = 1'b0; wrt = 1'b0; cmd = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
        wrt8 = 1'b0; cmd8 = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", data, 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, slave 0
        start_xfer(16'hA5C3, 16'h3C5A, 1'b0, 1'b0, 1'b0);
        check("m0_setup_ss_n", ss_n, 2'b10);
        check("m0_setup_sclk", sclk, 1'b0);
        check("m0_setup_mosi", mosi, 1'b1);
        check("m0_setup_busy", busy, 1'b1);
        wait_done(600);
        @(negedge clk);
        check("m0_idle_sclk", sclk, 1'b0);

        // mode 3, slave 1
        start_xfer(16'h8001, 16'hFFFE, 1'b1, 1'b1, 1'b1);
        check("m3_setup_sclk", sclk, 1'b1);
        check("m3_setup_ss_n", ss_n, 2'b01);
        check("m3_setup_mosi", mosi, 1'b1);
        wait_done(600);
        @(negedge clk);
        check("m3_idle_sclk", sclk, 1'b1);
        check("m3_idle_mosi", mosi, 1'b0);

        // wrt during a transfer is ignored
        n0 = n_done;
        start_xfer(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0);
        repeat (99) @(negedge clk);
        cmd = 16'h1234; wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        check("ign_busy", busy, 1'b1);
        wait_done(600);
        repeat (600) @(negedge clk);
        check("ign_done_count", n_done - n0, 1);

        // back-to-back with wrt held across done
        @(negedge clk);
        cmd = 16'hC0DE; ss_sel = 1'b0; cpol = 1'b0; cpha = 1'b0;
        slv_cpol = 1'b0; slv_cpha = 1'b0; wrt = 1'b1;
        rsp_q.push_back(16'h0F0F);
        sb_q.push_back('{data: 16'h0F0F, mosi: 16'hC0DE, ss: 2'b10});
        rsp_q.push_back(16'hB00B);
        sb_q.push_back('{data: 16'hB00B, mosi: 16'h7E57, ss: 2'b10});
        @(negedge clk);
        cmd = 16'h7E57;
        wait_done(600);
        check("b2b_gap_ss_n", ss_n, 2'b11);
        @(negedge clk);
        wrt = 1'b0;
        check("b2b_restart_ss_n", ss_n, 2'b10);
        check("b2b_restart_busy", busy, 1'b1);
        wait_done(600);
        @(negedge clk);

        // reset in SHIFT just after SCLK edge index 10
        n0 = n_done;
        start_xfer(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        repeat (184) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_sclk", sclk, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 2'b11);
        check("abort_sclk", sclk, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_data", data, 16'h0);
        check("abort_done", done, 1'b0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("abort_no_done", n_done - n0, 0);

        // 8-bit loopback, no slave selected
        @(negedge clk);
        cmd8 = 8'h5A; wrt8 = 1'b1;
        @(negedge clk);
        wrt8 = 1'b0;
        t0 = cyc;
        ss8_and = 1'b1;
        n = 0;
        while (!done8 && n < 200) begin
            ss8_and = ss8_and & ss_n8[0];
            @(negedge clk);
            n++;
        end
        check("w8_done_seen", done8, 1'b1);
        check("w8_latency", cyc - t0, LAT8);
        check("w8_data", data8, 8'h5A);
        check("w8_ss_n", ss8_and, 1'b1);
        $display("xfer8 done: data=%h cycle=%0d", data8, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
